// File: rtl/input_snapshot_writer.sv
// input_snapshot_writer
//
// Debounces the raw push-buttons and latches the latest accelerometer word. On every sample
// period it snapshots both values and writes them, button word first, into two fixed words of
// the shared system BRAM through the port-B arbiter using a request/grant handshake.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-low; clears all state
//   buttons_n    raw buttons, active-low, asynchronous to clock
//   accel_data   accelerometer sample, latched when accel_valid=1
//   accel_valid  single-cycle strobe
//   mem_gnt      arbiter grant of port B
//   mem_req      request for port B
//   mem_we       write enable, port B
//   mem_addr     write address (0 when mem_we=0)
//   mem_data     write data (0 when mem_we=0)
//   button_state debounced buttons, active-high, zero-extended to 16 bits
//   accel_state  last latched accelerometer value
//   overrun      sticky: a sample tick arrived while a snapshot was still pending
module input_snapshot_writer #(
  parameter int unsigned                SYS_DATA_WIDTH = 16,
  parameter int unsigned                SYS_ADDR_WIDTH = 16,
  parameter int unsigned                NUM_BUTTONS    = 4,
  parameter logic [SYS_ADDR_WIDTH-1:0]  BUTTON_ADDR    = 16'hFFF0,
  parameter logic [SYS_ADDR_WIDTH-1:0]  ACCEL_ADDR     = 16'hFFF1,
  parameter int unsigned                DEBOUNCE_COUNT = 250000,
  parameter int unsigned                SAMPLE_COUNT   = 833333
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_BUTTONS-1:0]    buttons_n,
  input  logic [15:0]               accel_data,
  input  logic                      accel_valid,
  input  logic                      mem_gnt,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [SYS_ADDR_WIDTH-1:0] mem_addr,
  output logic [SYS_DATA_WIDTH-1:0] mem_data,
  output logic [15:0]               button_state,
  output logic [15:0]               accel_state,
  output logic                      overrun
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_COUNT);
  localparam int unsigned SmpW = $clog2(SAMPLE_COUNT);
  localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_COUNT - 1);
  localparam logic [SmpW-1:0] SmpMax = SmpW'(SAMPLE_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWrBtn, StWrAcc} state_e;

  // ---------------------------------------------------------------------------
  // Button synchronizer and debounce
  // ---------------------------------------------------------------------------
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] stable_q, stable_d;
  logic [DbW-1:0]         db_cnt_q [NUM_BUTTONS];
  logic [DbW-1:0]         db_cnt_d [NUM_BUTTONS];

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= ~buttons_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign button_state = 16'(stable_q);

  // ---------------------------------------------------------------------------
  // Accelerometer latch
  // ---------------------------------------------------------------------------
  logic [15:0] accel_q, accel_d;

  always_comb begin
    accel_d = accel_valid ? accel_data : accel_q;
  end

  assign accel_state = accel_q;

  // ---------------------------------------------------------------------------
  // Sample timer, snapshot and write FSM
  // ---------------------------------------------------------------------------
  logic [SmpW-1:0]           timer_q, timer_d;
  logic                      tick;
  state_e                    state_q, state_d;
  logic [15:0]               snap_btn_q, snap_btn_d;
  logic [15:0]               snap_acc_q, snap_acc_d;
  logic                      overrun_q, overrun_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [SYS_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [SYS_DATA_WIDTH-1:0] mem_data_q, mem_data_d;

  always_comb begin
    tick       = (timer_q == SmpMax);
    timer_d    = tick ? '0 : timer_q + SmpW'(1);
    state_d    = state_q;
    snap_btn_d = snap_btn_q;
    snap_acc_d = snap_acc_q;
    overrun_d  = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          // Snapshot takes the pre-edge values, so a coincident accel strobe is not seen.
          snap_btn_d = button_state;
          snap_acc_d = accel_q;
          state_d    = StReq;
        end
      end
      StReq:   if (mem_gnt) state_d = StWrBtn;
      // Losing the grant mid-sequence restarts from the button word.
      StWrBtn: state_d = mem_gnt ? StWrAcc : StReq;
      StWrAcc: state_d = mem_gnt ? StIdle : StReq;
      default: state_d = StIdle;
    endcase

    if (tick && (state_q != StIdle)) overrun_d = 1'b1;

    // Outputs are decoded from the next state so they come straight out of flops.
    mem_req_d  = (state_d != StIdle);
    mem_we_d   = 1'b0;
    mem_addr_d = '0;
    mem_data_d = '0;
    if (state_d == StWrBtn) begin
      mem_we_d   = 1'b1;
      mem_addr_d = BUTTON_ADDR;
      mem_data_d = SYS_DATA_WIDTH'(snap_btn_d);
    end else if (state_d == StWrAcc) begin
      mem_we_d   = 1'b1;
      mem_addr_d = ACCEL_ADDR;
      mem_data_d = SYS_DATA_WIDTH'(snap_acc_d);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accel_q    <= '0;
      timer_q    <= '0;
      state_q    <= StIdle;
      snap_btn_q <= '0;
      snap_acc_q <= '0;
      overrun_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      accel_q    <= accel_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
      snap_btn_q <= snap_btn_d;
      snap_acc_q <= snap_acc_d;
      overrun_q  <= overrun_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_input_snapshot_writer.sv
// Self-checking bench for input_snapshot_writer (DEBOUNCE_COUNT=4, SAMPLE_COUNT=20).
// A behavioural model is stepped on every rising edge and every DUT output is compared with
// it on the falling edge; directed scenarios are followed by randomized stimulus.
module tb_input_snapshot_writer;

  localparam int unsigned DC = 4;
  localparam int unsigned SC = 20;
  localparam logic [15:0] BA = 16'hFFF0;
  localparam logic [15:0] AA = 16'hFFF1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  buttons_n = 4'hF;
  logic [15:0] accel_data = '0;
  logic        accel_valid = 1'b0;
  logic        mem_gnt = 1'b0;
  logic        mem_req, mem_we, overrun;
  logic [15:0] mem_addr, mem_data, button_state, accel_state;

  always #5 clock = ~clock;

  input_snapshot_writer #(
    .SYS_DATA_WIDTH(16),
    .SYS_ADDR_WIDTH(16),
    .NUM_BUTTONS   (4),
    .BUTTON_ADDR   (BA),
    .ACCEL_ADDR    (AA),
    .DEBOUNCE_COUNT(DC),
    .SAMPLE_COUNT  (SC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .buttons_n   (buttons_n),
    .accel_data  (accel_data),
    .accel_valid (accel_valid),
    .mem_gnt     (mem_gnt),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .button_state(button_state),
    .accel_state (accel_state),
    .overrun     (overrun)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [3:0]  m_s1, m_s2, m_stable;
  int          m_run [4];      // consecutive synchronized samples disagreeing with stable
  logic [15:0] m_accel, m_snap_b, m_snap_a;
  int          m_timer;
  int          m_words;        // -1: no snapshot pending, 0: waiting for grant,
                               //  1: button word on the bus, 2: accel word on the bus
  logic        m_ovr;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0;
    for (int b = 0; b < 4; b++) m_run[b] = 0;
    m_accel = '0; m_snap_b = '0; m_snap_a = '0;
    m_timer = 0; m_words = -1; m_ovr = 1'b0;
  endtask

  task automatic model_step();
    bit tick;
    tick    = (m_timer == SC - 1);
    m_timer = (m_timer + 1) % SC;
    if (m_words < 0) begin
      if (tick) begin
        m_snap_b = {12'h000, m_stable};
        m_snap_a = m_accel;
        m_words  = 0;
      end
    end else begin
      if (tick) m_ovr = 1'b1;
      if (!mem_gnt)         m_words = 0;
      else if (m_words < 2) m_words = m_words + 1;
      else                  m_words = -1;
    end
    if (accel_valid) m_accel = accel_data;
    for (int b = 0; b < 4; b++) begin
      if (m_s2[b] != m_stable[b]) begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          m_stable[b] = m_s2[b];
          m_run[b]    = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = ~buttons_n;
  endtask

  task automatic compare_all();
    logic [15:0] ea, ed;
    ea = (m_words == 1) ? BA : (m_words == 2) ? AA : 16'h0000;
    ed = (m_words == 1) ? m_snap_b : (m_words == 2) ? m_snap_a : 16'h0000;
    check_eq("mem_req", mem_req, m_words >= 0);
    check_eq("mem_we", mem_we, m_words >= 1);
    check_eq("mem_addr", mem_addr, ea);
    check_eq("mem_data", mem_data, ed);
    check_eq("button_state", button_state, {12'h000, m_stable});
    check_eq("accel_state", accel_state, m_accel);
    check_eq("overrun", overrun, m_ovr);
  endtask

  // Advance one clock: model follows the edge, outputs compared on the falling edge.
  task automatic one_cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    cyc++;
    compare_all();
  endtask

  task automatic rand_inputs();
    int b;
    if ($urandom_range(5) == 0) begin
      b = $urandom_range(3);
      buttons_n[b] = ~buttons_n[b];
    end
    accel_valid = ($urandom_range(3) == 0);
    accel_data  = 16'($urandom);
    if ($urandom_range(9) < 3) mem_gnt = ~mem_gnt;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    cyc = 0;
    compare_all();
  endtask

  initial begin
    int first_wr, t0, n;
    logic [15:0] addrs [$];

    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    release_reset();

    // Constant grant: first snapshot writes at cycles 21 and 22 with zero data.
    mem_gnt  = 1'b1;
    first_wr = -1;
    for (int i = 0; i < 45; i++) begin
      one_cycle();
      if (mem_we && mem_gnt && first_wr < 0) first_wr = cyc;
    end
    check_eq("first_wr_cycle", first_wr, 21);

    // Debounce latency and glitch rejection.
    buttons_n = 4'b1010;
    t0 = cyc;
    for (int i = 0; i < 20 && button_state != 16'h0005; i++) one_cycle();
    check_eq("btn_latency", cyc - t0, 6);
    buttons_n = 4'b0010;
    repeat (2) one_cycle();
    buttons_n = 4'b1010;
    repeat (10) one_cycle();
    check_eq("btn_glitch", button_state, 16'h0005);

    // Accelerometer latch and its appearance in the next snapshot.
    accel_data  = 16'h1234;
    accel_valid = 1'b1;
    one_cycle();
    accel_valid = 1'b0;
    check_eq("accel_latch", accel_state, 16'h1234);
    for (int i = 0; i < 60 && !(mem_we && mem_addr == AA); i++) one_cycle();
    check_eq("accel_wr_data", mem_data, 16'h1234);

    // Grant withheld across a second tick: overrun, then one two-word write.
    mem_gnt = 1'b0;
    for (int i = 0; i < 40 && !mem_req; i++) one_cycle();
    check_eq("req_seen", mem_req, 1'b1);
    n = 0;
    for (int i = 0; i < 25; i++) begin
      one_cycle();
      if (mem_we) n++;
    end
    check_eq("no_wr_without_gnt", n, 0);
    check_eq("overrun_set", overrun, 1'b1);
    mem_gnt = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      one_cycle();
      if (mem_we && mem_gnt) n++;
    end
    check_eq("single_snapshot_wr", n, 2);

    // Grant dropped during the accel write: restart from the button word.
    for (int i = 0; i < 40 && !(mem_we && mem_addr == BA); i++) one_cycle();
    check_eq("wrbtn_seen", mem_addr, BA);
    one_cycle();
    check_eq("wracc_seen", mem_addr, AA);
    mem_gnt = 1'b0;
    one_cycle();
    mem_gnt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      one_cycle();
      if (mem_we && mem_gnt) addrs.push_back(mem_addr);
    end
    check_eq("retry_count", addrs.size(), 2);
    if (addrs.size() >= 2) begin
      check_eq("retry_first", addrs[0], BA);
      check_eq("retry_second", addrs[1], AA);
    end

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      one_cycle();
      rand_inputs();
    end

    // Asynchronous reset during the button write.
    mem_gnt     = 1'b1;
    accel_valid = 1'b0;
    for (int i = 0; i < 40 && !(mem_we && mem_addr == BA); i++) one_cycle();
    check_eq("wrbtn_before_rst", mem_we, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_req", mem_req, 1'b0);
    check_eq("rst_we", mem_we, 1'b0);
    check_eq("rst_addr", mem_addr, 16'h0000);
    check_eq("rst_data", mem_data, 16'h0000);
    check_eq("rst_btn", button_state, 16'h0000);
    check_eq("rst_accel", accel_state, 16'h0000);
    check_eq("rst_overrun", overrun, 1'b0);
    @(posedge clock);
    release_reset();
    n = 0;
    for (int i = 0; i < 19; i++) begin
      one_cycle();
      if (mem_we) n++;
    end
    check_eq("no_wr_after_rst", n, 0);

    for (int i = 0; i < 300; i++) begin
      one_cycle();
      rand_inputs();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
